// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and receiver FSM state encoding.
// Intended for reuse by a future transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_rx_state_t;

endpackage

// File: rtl/ext_uart_rx_if.sv
// Core-facing read port of the UART receiver: {valid, data} with one-bit ready.
// The master is the core side, the slave is ext_uart_rx.
interface ext_uart_rx_if;
  import uart_pkg::*;

  logic                      rd_ready;
  logic                      rd_valid;
  logic [UART_DATA_BITS-1:0] rd_data;
  logic                      overrun;

  modport master (output rd_ready, input rd_valid, rd_data, overrun);
  modport slave  (input rd_ready, output rd_valid, rd_data, overrun);

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push into a full FIFO is accepted
// only when a pop frees the head slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Storage is never reset, so the head is masked to zero while empty.
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ext_uart_rx.sv
// 8N1 UART receiver with 2-flop synchronizer, mid-bit sampling and a read FIFO.
// Define UART_RX_DROP_BAD_EN to discard bytes whose stop bit is low.
module ext_uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         rx,
  ext_uart_rx_if.slave rd_if
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [TW-1:0] BIT_RELOAD  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_RELOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT    = BW'(UART_DATA_BITS - 1);

  logic                      rx_p0;
  logic                      rx_p1;
  logic                      rx_s;
  uart_rx_state_t            state_q;
  logic [TW-1:0]             timer_q;
  logic [BW-1:0]             bit_idx_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      expire;
  logic                      stop_hit;
  logic                      push_vld;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      overrun_q;

  // Stage p0/p1: synchronizer, idles high so reset never looks like a start bit
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_s   = rx_p1;
  assign expire = (timer_q == '0);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
    end else begin
      if (!expire) timer_q <= timer_q - 1'b1;
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            timer_q <= HALF_RELOAD;
            state_q <= START;
          end
        end
        START: begin
          if (expire) begin
            if (rx_s) begin
              state_q <= IDLE;
            end else begin
              timer_q   <= BIT_RELOAD;
              bit_idx_q <= '0;
              state_q   <= DATA;
            end
          end
        end
        DATA: begin
          if (expire) begin
            timer_q   <= BIT_RELOAD;
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == LAST_BIT) state_q <= STOP;
          end
        end
        STOP: begin
          if (expire) state_q <= rx_s ? IDLE : WAIT_HIGH;
        end
        WAIT_HIGH: begin
          if (rx_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (state_q == DATA && expire) shift_q <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
  end

  assign stop_hit = (state_q == STOP) && expire;

`ifdef UART_RX_DROP_BAD_EN
  assign push_vld = stop_hit && rx_s;
`else
  assign push_vld = stop_hit;
`endif

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .push      (push_vld),
    .push_data (shift_q),
    .pop       (rd_if.rd_ready),
    .pop_data  (rd_if.rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A full FIFO is non-empty, so rd_ready alone means a slot is freed this cycle.
  always_ff @(posedge CLK) begin
    if (!RST_N)                                         overrun_q <= 1'b0;
    else if (push_vld && fifo_full && !rd_if.rd_ready)  overrun_q <= 1'b1;
  end

  assign rd_if.rd_valid = !fifo_empty;
  assign rd_if.overrun  = overrun_q;

endmodule

// File: tb/tb_ext_uart_rx.sv
// Directed and randomized bench for ext_uart_rx with a queue-based byte model.
module tb_ext_uart_rx;
  import uart_pkg::*;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int H     = CPB / 2;
  localparam int LAT   = H + 9 * CPB + 3;
`ifdef UART_RX_DROP_BAD_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  logic rx    = 1'b1;

  ext_uart_rx_if u_if ();

  ext_uart_rx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .rx    (rx),
    .rd_if (u_if)
  );

  always #5 CLK = ~CLK;

  int           checks = 0;
  int           errors = 0;
  byte unsigned exp_q[$];
  bit           exp_ovr = 1'b0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a received frame is kept if its stop bit is good (or bad bytes are kept),
  // lands in the queue if there is room, otherwise it is lost and overrun latches.
  task automatic model_frame(input byte unsigned b, input bit stop_ok);
    if (stop_ok || !DROP) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else                      exp_ovr = 1'b1;
    end
  endtask

  task automatic send_bit(input bit v);
    rx = v;
    repeat (CPB) tick();
  endtask

  task automatic send_frame(input byte unsigned b, input bit stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic drain(input string tag);
    byte unsigned e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, u_if.rd_valid, 1);
      check({tag, "_data"}, u_if.rd_data, e);
      u_if.rd_ready = 1'b1;
      tick();
      u_if.rd_ready = 1'b0;
    end
    check({tag, "_empty"}, u_if.rd_valid, 0);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    repeat (3) tick();
    RST_N = 1'b1;
    tick();
    exp_q.delete();
    exp_ovr = 1'b0;
  endtask

  initial begin
    byte unsigned b;
    bit           bad;
    int           n;
    u_if.rd_ready = 1'b0;

    repeat (3) tick();
    check("rst_valid", u_if.rd_valid, 0);
    check("rst_data", u_if.rd_data, 0);
    check("rst_ovr", u_if.overrun, 0);
    RST_N = 1'b1;
    tick();
    check("rst_state", dut.state_q, IDLE);

    // Single frame latency
    fork
      send_frame(8'h55, 1'b1);
      begin
        repeat (LAT - 1) tick();
        check("lat_early", u_if.rd_valid, 0);
        tick();
        check("lat_valid", u_if.rd_valid, 1);
        check("lat_data", u_if.rd_data, 8'h55);
        check("lat_ovr", u_if.overrun, 0);
      end
    join
    model_frame(8'h55, 1'b1);
    drain("lat");

    // Short low glitch
    rx = 1'b0;
    repeat (5) tick();
    rx = 1'b1;
    repeat (2 * CPB) tick();
    check("glitch_state", dut.state_q, IDLE);
    check("glitch_valid", u_if.rd_valid, 0);

    // Overrun with five back-to-back frames
    for (int i = 1; i <= 5; i++) begin
      send_frame(byte'(i), 1'b1);
      model_frame(byte'(i), 1'b1);
    end
    check("ovr_flag", u_if.overrun, exp_ovr);
    drain("ovr");

    // Full FIFO with a pop in the push cycle
    do_reset();
    check("ovr_cleared", u_if.overrun, 0);
    for (int i = 1; i <= 4; i++) begin
      send_frame(byte'(i), 1'b1);
      model_frame(byte'(i), 1'b1);
    end
    fork
      send_frame(8'h05, 1'b1);
      begin
        repeat (H + 2 + 9 * CPB) tick();
        u_if.rd_ready = 1'b1;
        check("simul_head", u_if.rd_data, exp_q.pop_front());
        tick();
        u_if.rd_ready = 1'b0;
      end
    join
    model_frame(8'h05, 1'b1);
    check("simul_ovr", u_if.overrun, exp_ovr);
    drain("simul");

    // Framing error followed by a long break
    send_frame(8'hA5, 1'b0);
    repeat (40) tick();
    rx = 1'b1;
    repeat (2 * CPB) tick();
    model_frame(8'hA5, 1'b0);
    check("ferr_ovr", u_if.overrun, exp_ovr);
    drain("ferr");

    // Reset in the middle of a frame
    send_frame(8'h11, 1'b1);
    model_frame(8'h11, 1'b1);
    check("prerst_valid", u_if.rd_valid, 1);
    fork
      send_frame(8'h3C, 1'b1);
      begin
        repeat (3 * CPB) tick();
        RST_N = 1'b0;
        repeat (2) tick();
        check("midrst_valid", u_if.rd_valid, 0);
        check("midrst_data", u_if.rd_data, 0);
        check("midrst_ovr", u_if.overrun, 0);
        repeat (6 * CPB) tick();
        RST_N = 1'b1;
        exp_q.delete();
        exp_ovr = 1'b0;
        tick();
        check("postrst_valid", u_if.rd_valid, 0);
        check("postrst_data", u_if.rd_data, 0);
        check("postrst_ovr", u_if.overrun, 0);
      end
    join
    repeat (CPB) tick();
    send_frame(8'h7E, 1'b1);
    model_frame(8'h7E, 1'b1);
    drain("rst7e");

    // Randomized bursts
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        b   = byte'($urandom);
        bad = ($urandom_range(0, 5) == 0);
        send_frame(b, !bad);
        model_frame(b, !bad);
        rx = 1'b1;
        if (bad) repeat (2 * CPB) tick();
        else     repeat ($urandom_range(0, 2) * CPB) tick();
      end
      check("rand_ovr", u_if.overrun, exp_ovr);
      drain("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
